// File: rtl/mfrc522_card_poller.sv
// MFRC522 card poller: soft-resets and configures the reader, then repeatedly
// sends REQA, polls ComIrqReg and reads the 2-byte ATQA from the FIFO.
module mfrc522_card_poller #(
    parameter int RESET_WAIT_CLKS    = 50000,
    parameter int POLL_INTERVAL_CLKS = 1000000,
    parameter int IRQ_POLL_MAX       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_is_write,
    output logic [5:0]  cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic [7:0]  cmd_rdata,
    input  logic        cmd_done,
    output logic        init_done,
    output logic        busy,
    output logic        poll_done,
    output logic        card_present,
    output logic [15:0] atqa,
    output logic        timeout_err,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_RST_CMD  = 4'd0, S_RST_WAIT = 4'd1, S_INIT     = 4'd2, S_WAIT     = 4'd3,
        S_REQ      = 4'd4, S_IRQ_RD   = 4'd5, S_LVL_RD   = 4'd6, S_FIFO_RD0 = 4'd7,
        S_FIFO_RD1 = 4'd8, S_REPORT   = 4'd9
    } state_t;

    // Handshake: fields are registered together with cmd_valid and held until the
    // edge where cmd_valid && cmd_ready; the block then waits for the cmd_done pulse
    // and only issues the next command one cycle after it.
    typedef enum logic [1:0] {PH_ISSUE, PH_ACCEPT, PH_DONE} phase_t;

    localparam logic [31:0] RST_LAST  = 32'(RESET_WAIT_CLKS - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL_CLKS - 1);
    localparam logic [15:0] IRQ_LAST  = 16'(IRQ_POLL_MAX);

    state_t      r_state;
    phase_t      r_phase;
    logic [2:0]  r_step;
    logic [31:0] r_cnt;
    logic [15:0] r_irq_cnt;
    logic [15:0] r_shadow;
    logic        r_res_card;
    logic        r_res_timeout;

    logic        w_is_write;
    logic [5:0]  w_addr;
    logic [7:0]  w_wdata;
    logic [15:0] w_irq_next;

    assign dbg_state  = r_state;
    assign w_irq_next = r_irq_cnt + 16'd1;

    always_comb begin
        w_is_write = 1'b0;
        w_addr     = 6'h00;
        w_wdata    = 8'h00;
        case (r_state)
            S_RST_CMD: {w_is_write, w_addr, w_wdata} = {1'b1, 6'h01, 8'h0F};
            S_INIT: begin
                case (r_step)
                    3'd0:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h2A, 8'h80};
                    3'd1:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h2B, 8'hA9};
                    3'd2:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h2C, 8'h03};
                    3'd3:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h2D, 8'hE8};
                    3'd4:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h15, 8'h40};
                    3'd5:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h11, 8'h3D};
                    default: {w_is_write, w_addr, w_wdata} = {1'b1, 6'h14, 8'h83};
                endcase
            end
            S_REQ: begin
                case (r_step)
                    3'd0:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h01, 8'h00};
                    3'd1:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h04, 8'h7F};
                    3'd2:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h0A, 8'h80};
                    3'd3:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h0D, 8'h07};
                    3'd4:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h09, 8'h26};
                    3'd5:    {w_is_write, w_addr, w_wdata} = {1'b1, 6'h01, 8'h0C};
                    default: {w_is_write, w_addr, w_wdata} = {1'b1, 6'h0D, 8'h87};
                endcase
            end
            S_IRQ_RD:               w_addr = 6'h04;
            S_LVL_RD:               w_addr = 6'h0A;
            S_FIFO_RD0, S_FIFO_RD1: w_addr = 6'h09;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RST_CMD;
            r_phase       <= PH_ISSUE;
            r_step        <= 3'd0;
            r_cnt         <= 32'd0;
            r_irq_cnt     <= 16'd0;
            r_shadow      <= 16'h0000;
            r_res_card    <= 1'b0;
            r_res_timeout <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_is_write  <= 1'b0;
            cmd_addr      <= 6'h00;
            cmd_wdata     <= 8'h00;
            init_done     <= 1'b0;
            busy          <= 1'b0;
            poll_done     <= 1'b0;
            card_present  <= 1'b0;
            atqa          <= 16'h0000;
            timeout_err   <= 1'b0;
        end else begin
            poll_done   <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                S_RST_WAIT: begin
                    if (r_cnt == RST_LAST) begin
                        r_state <= S_INIT;
                        r_step  <= 3'd0;
                        r_phase <= PH_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    // Interval counter saturates; enable only matters once it has expired.
                    if (r_cnt == POLL_LAST) begin
                        if (enable) begin
                            busy    <= 1'b1;
                            r_state <= S_REQ;
                            r_step  <= 3'd0;
                            r_phase <= PH_ISSUE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_REPORT: begin
                    card_present <= r_res_card;
                    atqa         <= r_res_card ? r_shadow : 16'h0000;
                    poll_done    <= 1'b1;
                    timeout_err  <= r_res_timeout;
                    busy         <= 1'b0;
                    r_state      <= S_WAIT;
                    r_cnt        <= 32'd0;
                end
                default: begin
                    case (r_phase)
                        PH_ISSUE: begin
                            cmd_valid    <= 1'b1;
                            cmd_is_write <= w_is_write;
                            cmd_addr     <= w_addr;
                            cmd_wdata    <= w_wdata;
                            r_phase      <= PH_ACCEPT;
                        end
                        PH_ACCEPT: begin
                            if (cmd_ready) begin
                                cmd_valid <= 1'b0;
                                r_phase   <= PH_DONE;
                            end
                        end
                        default: begin
                            if (cmd_done) begin
                                r_phase <= PH_ISSUE;
                                case (r_state)
                                    S_RST_CMD: begin
                                        r_state <= S_RST_WAIT;
                                        r_cnt   <= 32'd0;
                                    end
                                    S_INIT: begin
                                        if (r_step == 3'd6) begin
                                            init_done <= 1'b1;
                                            r_state   <= S_WAIT;
                                            r_cnt     <= 32'd0;
                                        end else begin
                                            r_step <= r_step + 3'd1;
                                        end
                                    end
                                    S_REQ: begin
                                        if (r_step == 3'd6) begin
                                            r_state   <= S_IRQ_RD;
                                            r_irq_cnt <= 16'd0;
                                        end else begin
                                            r_step <= r_step + 3'd1;
                                        end
                                    end
                                    S_IRQ_RD: begin
                                        // RxIRq wins even on the final permitted read.
                                        r_irq_cnt <= w_irq_next;
                                        if (cmd_rdata[5]) begin
                                            r_state <= S_LVL_RD;
                                        end else if (cmd_rdata[0]) begin
                                            r_res_card    <= 1'b0;
                                            r_res_timeout <= 1'b0;
                                            r_state       <= S_REPORT;
                                        end else if (w_irq_next == IRQ_LAST) begin
                                            r_res_card    <= 1'b0;
                                            r_res_timeout <= 1'b1;
                                            r_state       <= S_REPORT;
                                        end
                                    end
                                    S_LVL_RD: begin
                                        if (cmd_rdata[6:0] == 7'd2) begin
                                            r_state <= S_FIFO_RD0;
                                        end else begin
                                            r_res_card    <= 1'b0;
                                            r_res_timeout <= 1'b0;
                                            r_state       <= S_REPORT;
                                        end
                                    end
                                    S_FIFO_RD0: begin
                                        r_shadow[7:0] <= cmd_rdata;
                                        r_state       <= S_FIFO_RD1;
                                    end
                                    S_FIFO_RD1: begin
                                        r_shadow[15:8] <= cmd_rdata;
                                        r_res_card     <= 1'b1;
                                        r_res_timeout  <= 1'b0;
                                        r_state        <= S_REPORT;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfrc522_card_poller.sv
// Directed bench for mfrc522_card_poller: a register-interface responder logs every
// accepted command and the main sequence compares the log and outputs against hand values.
module tb_mfrc522_card_poller;

    localparam int RW  = 20;
    localparam int PI  = 30;
    localparam int IPM = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_write;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_rdata;
    logic        cmd_done;
    logic        init_done;
    logic        busy;
    logic        poll_done;
    logic        card_present;
    logic [15:0] atqa;
    logic        timeout_err;
    logic [3:0]  dbg_state;

    logic [14:0] log_q[$];
    logic [14:0] exp_q[$];
    logic [7:0]  rd_q[$];
    int          stall_left;
    int          unstable;
    int          n_checks;
    int          n_errors;
    int          low_cnt;
    int          n;

    mfrc522_card_poller #(
        .RESET_WAIT_CLKS(RW),
        .POLL_INTERVAL_CLKS(PI),
        .IRQ_POLL_MAX(IPM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_rdata(cmd_rdata),
        .cmd_done(cmd_done), .init_done(init_done), .busy(busy), .poll_done(poll_done),
        .card_present(card_present), .atqa(atqa), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder: accepts one cycle after seeing cmd_valid (unless stalled), completes one cycle later.
    initial begin : responder
        logic        done_due;
        logic        due_read;
        logic        snap_valid;
        logic [14:0] snap;
        logic [14:0] cur;
        done_due   = 1'b0;
        due_read   = 1'b0;
        snap_valid = 1'b0;
        snap       = '0;
        cmd_ready  = 1'b0;
        cmd_done   = 1'b0;
        cmd_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            cmd_done  = 1'b0;
            cmd_ready = 1'b0;
            cur = {cmd_is_write, cmd_addr, cmd_is_write ? cmd_wdata : 8'h00};
            if (!rst_n) begin
                done_due   = 1'b0;
                snap_valid = 1'b0;
            end else begin
                if (done_due) begin
                    cmd_done  = 1'b1;
                    cmd_rdata = 8'h00;
                    if (due_read && rd_q.size() > 0) cmd_rdata = rd_q.pop_front();
                    done_due = 1'b0;
                end
                if (cmd_valid) begin
                    if (snap_valid && snap !== cur) unstable++;
                    if (stall_left > 0) begin
                        snap       = cur;
                        snap_valid = 1'b1;
                        stall_left--;
                    end else begin
                        snap_valid = 1'b0;
                        cmd_ready  = 1'b1;
                        log_q.push_back(cur);
                        done_due   = 1'b1;
                        due_read   = !cmd_is_write;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_w(input logic [5:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic exp_r(input logic [5:0] a);
        exp_q.push_back({1'b0, a, 8'h00});
    endtask

    task automatic exp_req();
        exp_w(6'h01, 8'h00); exp_w(6'h04, 8'h7F); exp_w(6'h0A, 8'h80); exp_w(6'h0D, 8'h07);
        exp_w(6'h09, 8'h26); exp_w(6'h01, 8'h0C); exp_w(6'h0D, 8'h87);
    endtask

    task automatic exp_irq(input int cnt);
        for (int i = 0; i < cnt; i++) exp_r(6'h04);
    endtask

    task automatic exp_card_tail();
        exp_r(6'h0A); exp_r(6'h09); exp_r(6'h09);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) check(tag, log_q[i], exp_q[i]);
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_poll();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!poll_done && k < 3000);
        check("poll_done_seen", poll_done, 1);
    endtask

    task automatic wait_busy();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!busy && k < 3000);
        check("busy_rise", busy, 1);
    endtask

    task automatic check_result(input string tag, input logic card, input logic [15:0] a,
                                input logic to);
        check({tag, "_card"}, card_present, card);
        check({tag, "_atqa"}, atqa, a);
        check({tag, "_timeout"}, timeout_err, to);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        stall_left = 0;
        unstable   = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_valid", cmd_valid, 0);
        check("rst_is_write", cmd_is_write, 0);
        check("rst_addr", cmd_addr, 0);
        check("rst_wdata", cmd_wdata, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 0);
        check("rst_poll_done", poll_done, 0);
        check("rst_card", card_present, 0);
        check("rst_atqa", atqa, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_state", dbg_state, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("valid_first_edge", cmd_valid, 1);
        check("softreset_fields", {cmd_is_write, cmd_addr, cmd_wdata}, {1'b1, 6'h01, 8'h0F});

        // Low from the accept edge through RST_WAIT and the INIT issue cycle.
        low_cnt = 0;
        @(negedge clk);
        while (!cmd_valid && low_cnt < 1000) begin
            low_cnt++;
            @(negedge clk);
        end
        check("reset_wait_gap", low_cnt, RW + 2);

        n = 0;
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("init_done", init_done, 1);
        exp_w(6'h01, 8'h0F);
        exp_w(6'h2A, 8'h80); exp_w(6'h2B, 8'hA9); exp_w(6'h2C, 8'h03); exp_w(6'h2D, 8'hE8);
        exp_w(6'h15, 8'h40); exp_w(6'h11, 8'h3D); exp_w(6'h14, 8'h83);
        check_log("init");

        repeat (PI + 20) @(negedge clk);
        check("disabled_no_traffic", log_q.size(), 0);
        check("disabled_busy", busy, 0);

        // Card present after two empty IRQ reads.
        rd_q.delete();
        rd_q = '{8'h00, 8'h00, 8'h20, 8'h02, 8'h04, 8'h00};
        enable = 1'b1;
        wait_busy();
        wait_poll();
        check_result("card", 1, 16'h0004, 0);
        exp_req(); exp_irq(3); exp_card_tail();
        check_log("card_log");
        @(negedge clk);
        check("poll_done_pulse", poll_done, 0);

        // TimerIRq only: no card, no FIFO access.
        rd_q.delete();
        rd_q = '{8'h01};
        wait_poll();
        check_result("nocard", 0, 16'h0000, 0);
        exp_req(); exp_irq(1);
        check_log("nocard_log");

        // RxIRq and TimerIRq together: card path.
        rd_q.delete();
        rd_q = '{8'h21, 8'h02, 8'h12, 8'h34};
        wait_poll();
        check_result("prio", 1, 16'h3412, 0);
        exp_req(); exp_irq(1); exp_card_tail();
        check_log("prio_log");

        // ComIrqReg stays zero: timeout after IPM reads.
        rd_q.delete();
        wait_poll();
        check_result("timeout", 0, 16'h0000, 1);
        exp_req(); exp_irq(IPM);
        check_log("timeout_log");
        @(negedge clk);
        check("timeout_pulse", timeout_err, 0);

        // RxIRq on the last permitted read still reports a card.
        rd_q.delete();
        rd_q = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h02, 8'h11, 8'h22};
        wait_poll();
        check_result("lastread", 1, 16'h2211, 0);
        exp_req(); exp_irq(IPM); exp_card_tail();
        check_log("lastread_log");

        // Wrong FIFO level.
        rd_q.delete();
        rd_q = '{8'h20, 8'h03};
        wait_poll();
        check_result("level", 0, 16'h0000, 0);
        exp_req(); exp_irq(1); exp_r(6'h0A);
        check_log("level_log");

        // First REQ write stalled for 20 cycles.
        rd_q.delete();
        rd_q = '{8'h20, 8'h02, 8'hAA, 8'h55};
        stall_left = 20;
        wait_poll();
        check("stall_consumed", stall_left, 0);
        check("stall_stable", unstable, 0);
        check_result("slow", 1, 16'h55AA, 0);
        exp_req(); exp_irq(1); exp_card_tail();
        check_log("slow_log");

        // enable dropped mid-poll: cycle completes, then no more traffic.
        rd_q.delete();
        rd_q = '{8'h20, 8'h02, 8'h01, 8'h02};
        wait_busy();
        enable = 1'b0;
        wait_poll();
        check_result("drop", 1, 16'h0201, 0);
        exp_req(); exp_irq(1); exp_card_tail();
        check_log("drop_log");
        repeat (PI + 30) @(negedge clk);
        check("drop_halted", log_q.size(), 0);

        // Asynchronous reset while IRQ polling.
        rd_q.delete();
        enable = 1'b1;
        n = 0;
        while (log_q.size() < 8 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("irq_state", dbg_state, 5);
        rst_n = 1'b0;
        #1;
        check("arst_valid", cmd_valid, 0);
        check("arst_addr", cmd_addr, 0);
        check("arst_init_done", init_done, 0);
        check("arst_busy", busy, 0);
        check("arst_card", card_present, 0);
        check("arst_atqa", atqa, 0);
        check("arst_state", dbg_state, 0);
        repeat (2) @(negedge clk);
        log_q.delete();
        rst_n = 1'b1;
        n = 0;
        while (log_q.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp_w(6'h01, 8'h0F);
        check("rerun_cmd", log_q.size() > 0 ? log_q[0] : 15'h0, exp_q[0]);
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
